// File: rtl/cmd_queue_comm.sv
// cmd_queue_comm: buffers up to DEPTH commands of CMD_W bits and sends each one MSB byte first
// over a byte-wide UART TX handshake. It then waits, with a timeout, for a one-byte response
// and reports a status for every command.
// Ports: clk/rst (synchronous, active-high).
//   cmd_in/cmd_wr enqueue a command; full/empty/count show occupancy; ovf flags a dropped write.
//   tx_data/trmt/tx_done form the transmitter handshake.
//   rx_data/rx_rdy/clr_rx_rdy form the receiver handshake.
//   resp/resp_vld/cmd_ok/cmd_err/tmo report the per-command result; busy means not IDLE.
// Optional: define CMD_RETRY_EN to resend a timed-out command up to MAX_RETRY more times.
module cmd_queue_comm #(
  parameter int         CMD_W       = 16,
  parameter int         DEPTH       = 8,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         MAX_RETRY   = 2,
  parameter logic [7:0] RESP_DONE   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CMD_W-1:0]         cmd_in,
  input  logic                     cmd_wr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [7:0]               tx_data,
  output logic                     trmt,
  input  logic                     tx_done,
  input  logic [7:0]               rx_data,
  input  logic                     rx_rdy,
  output logic                     clr_rx_rdy,
  output logic [7:0]               resp,
  output logic                     resp_vld,
  output logic                     cmd_ok,
  output logic                     cmd_err,
  output logic                     tmo,
  output logic                     busy
);
  localparam int NBYTES = CMD_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_WAIT_TX   = 3'd3;
  localparam logic [2:0] S_WAIT_RESP = 3'd4;
  localparam logic [2:0] S_REPORT    = 3'd5;

  localparam logic [1:0]    IDX_TOP  = 2'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  // Reject parameter combinations the datapath cannot represent.
  if ((CMD_W % 8) != 0 || NBYTES < 1 || NBYTES > 4 || DEPTH < 2 || DEPTH > 64 ||
      (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2 || MAX_RETRY < 0) begin : g_bad_params
    $error("cmd_queue_comm: illegal parameter combination");
  end

  logic [2:0]       state;
  logic [CMD_W-1:0] sreg;
  logic [1:0]       idx;
  logic [1:0]       idx_m1;
  logic [TW-1:0]    tcnt;
  logic             rx_take;

`ifdef CMD_RETRY_EN
  localparam int          RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0]          retry;
`endif

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CMD_W-1:0] head;
  logic             push, pop;

  assign push  = cmd_wr && !full;
  assign pop   = (state == S_LOAD);  // LOAD is only entered with the FIFO non-empty
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= cmd_wr && full;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- sequencer ----------------
  // A byte is consumed once: clr_rx_rdy is high in the cycle after the take, and rx_rdy may
  // still be high then, so it must not be taken a second time.
  assign rx_take = rx_rdy && !clr_rx_rdy;
  assign idx_m1  = idx - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sreg       <= '0;
      idx        <= '0;
      tcnt       <= '0;
      tx_data    <= '0;
      resp       <= '0;
      clr_rx_rdy <= 1'b0;
      tmo        <= 1'b0;
`ifdef CMD_RETRY_EN
      retry      <= '0;
`endif
    end else begin
      // Every taken byte is cleared. Outside WAIT_RESP it is simply discarded.
      clr_rx_rdy <= rx_take;
      tmo        <= 1'b0;
      case (state)
        S_IDLE: if (!empty) state <= S_LOAD;
        S_LOAD: begin
          sreg    <= head;
          idx     <= IDX_TOP;
          tx_data <= 8'(head >> ((NBYTES - 1) * 8));
`ifdef CMD_RETRY_EN
          retry   <= '0;
`endif
          state   <= S_SEND;
        end
        S_SEND: state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (tx_done) begin
            if (idx != '0) begin
              idx     <= idx_m1;
              tx_data <= 8'(sreg >> {idx_m1, 3'b000});
              state   <= S_SEND;
            end else begin
              tcnt  <= '0;
              state <= S_WAIT_RESP;
            end
          end
        end
        S_WAIT_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (rx_take) begin
            // A response that arrives on the terminal count still counts.
            resp  <= rx_data;
            state <= S_REPORT;
          end else if (tcnt == TMO_LAST) begin
`ifdef CMD_RETRY_EN
            if (retry < RETRY_MAX) begin
              retry   <= retry + 1'b1;
              idx     <= IDX_TOP;
              tx_data <= 8'(sreg >> ((NBYTES - 1) * 8));
              state   <= S_SEND;
            end else begin
              tmo   <= 1'b1;
              state <= S_IDLE;
            end
`else
            tmo   <= 1'b1;
            state <= S_IDLE;
`endif
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign trmt     = (state == S_SEND);
  assign busy     = (state != S_IDLE);
  assign resp_vld = (state == S_REPORT);
  assign cmd_ok   = resp_vld && (resp == RESP_DONE);
  assign cmd_err  = (resp_vld && (resp != RESP_DONE)) || tmo;

endmodule

// File: tb/tb_cmd_queue_comm.sv
// Self-checking bench for cmd_queue_comm (CMD_W=16, DEPTH=8, TIMEOUT_CYC=100, MAX_RETRY=2).
// A negedge model plays the UART pair and scores transmitted bytes and status pulses
// against queues filled by the test tasks.
module tb_cmd_queue_comm;
  localparam int CMD_W = 16;
  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int MAXR  = 2;
`ifdef CMD_RETRY_EN
  localparam int ATTEMPTS = MAXR + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct packed {
    logic       vld;
    logic       ok;
    logic       err;
    logic       tmo;
    logic [7:0] resp;
  } stat_t;

  logic              clk, rst;
  logic [CMD_W-1:0]  cmd_in;
  logic              cmd_wr;
  logic              full, empty;
  logic [3:0]        count;
  logic              ovf;
  logic [7:0]        tx_data;
  logic              trmt, tx_done;
  logic [7:0]        rx_data;
  logic              rx_rdy, clr_rx_rdy;
  logic [7:0]        resp;
  logic              resp_vld, cmd_ok, cmd_err, tmo, busy;

  cmd_queue_comm #(.CMD_W(CMD_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR),
                   .RESP_DONE(8'hA5)) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_wr(cmd_wr), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .resp(resp),
    .resp_vld(resp_vld), .cmd_ok(cmd_ok), .cmd_err(cmd_err), .tmo(tmo), .busy(busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_trmt = 0, n_clr = 0, n_ovf = 0;

  logic [7:0] exp_bytes [$];
  stat_t      exp_stat  [$];

  // UART model controls (written only by the test tasks)
  bit         auto_tx = 1'b0;
  bit         auto_rx = 1'b0;
  logic [7:0] auto_rx_data = 8'hA5;
  int         tx_kick_seq = 0;
  int         rx_req_seq = 0;
  logic [7:0] rx_req_data = 8'h00;
  logic [7:0] last_resp = 8'h00;

  // UART model state (written only by the monitor)
  int         tx_cd = 0, rx_cd = 0, tx_done_cnt = 0;
  int         tx_kick_done = 0, rx_req_done = 0;
  logic [7:0] eb;
  stat_t      es;
  bit         fire;

  initial begin
    tx_done = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  end

  // Negedge monitor: scores outputs and drives tx_done / rx_rdy for the next rising edge.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      tx_cd = 0; rx_cd = 0; tx_done_cnt = 0; rx_rdy = 1'b0;
    end else begin
      if (clr_rx_rdy) begin n_clr++; rx_rdy = 1'b0; end
      if (trmt) begin
        n_trmt++;
        n_cmp++;
        if (exp_bytes.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte: trmt with tx_data=%h, no byte expected", tx_data);
        end else begin
          eb = exp_bytes.pop_front();
          if (tx_data !== eb) begin
            n_err++;
            $display("FAIL tx_byte: got %h, expected %h", tx_data, eb);
          end
        end
      end
      fire = 1'b0;
      if (tx_cd > 0) begin tx_cd--; if (tx_cd == 0) fire = 1'b1; end
      if (tx_kick_seq != tx_kick_done) begin tx_kick_done = tx_kick_seq; fire = 1'b1; end
      if (trmt && auto_tx) tx_cd = 5;
      if (fire) begin
        tx_done = 1'b1;
        tx_done_cnt++;
        if (auto_rx && (tx_done_cnt % 2 == 0)) rx_cd = 3;
      end
      if (rx_cd > 0) begin
        rx_cd--;
        if (rx_cd == 0) begin rx_rdy = 1'b1; rx_data = auto_rx_data; end
      end
      if (rx_req_seq != rx_req_done && !rx_rdy) begin
        rx_req_done = rx_req_seq; rx_rdy = 1'b1; rx_data = rx_req_data;
      end
      if (ovf) n_ovf++;
      if (resp_vld || cmd_ok || cmd_err || tmo) begin
        n_cmp++;
        if (exp_stat.size() == 0) begin
          n_err++;
          $display("FAIL status: unexpected vld/ok/err/tmo=%b%b%b%b resp=%h",
                   resp_vld, cmd_ok, cmd_err, tmo, resp);
        end else begin
          es = exp_stat.pop_front();
          if ({resp_vld, cmd_ok, cmd_err, tmo} !== {es.vld, es.ok, es.err, es.tmo}) begin
            n_err++;
            $display("FAIL status_flags: got vld/ok/err/tmo=%b%b%b%b, expected %b%b%b%b",
                     resp_vld, cmd_ok, cmd_err, tmo, es.vld, es.ok, es.err, es.tmo);
          end
          if (es.vld) begin
            n_cmp++;
            if (resp !== es.resp) begin
              n_err++;
              $display("FAIL status_resp: got %h, expected %h", resp, es.resp);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CMD_W-1:0] c);
    cmd_in = c;
    cmd_wr = 1'b1;
    tick(1);
    cmd_wr = 1'b0;
  endtask

  task automatic expect_bytes(input logic [CMD_W-1:0] c, input int times);
    for (int k = 0; k < times; k++) begin
      exp_bytes.push_back(c[15:8]);
      exp_bytes.push_back(c[7:0]);
    end
  endtask

  task automatic expect_resp(input logic [7:0] r);
    stat_t s;
    s.vld = 1'b1; s.ok = (r == 8'hA5); s.err = (r != 8'hA5); s.tmo = 1'b0; s.resp = r;
    exp_stat.push_back(s);
    last_resp = r;
  endtask

  task automatic wait_idle(input int budget, input string what);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      if (!busy && empty && exp_stat.size() == 0 && !rx_rdy) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: not idle after %0d cycles (busy=%b count=%0d pending=%0d), idle required",
               what, budget, busy, count, exp_stat.size());
    end
  endtask

  task automatic wait_trmts(input int target, input string what);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1);
      if (n_trmt >= target) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: trmt count %0d, required %0d", what, n_trmt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_wr = 1'b0; cmd_in = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if ({count, empty, full, ovf, busy} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_fifo: count/empty/full/ovf/busy=%0d/%b/%b/%b/%b, required 0/1/0/0/0",
               count, empty, full, ovf, busy);
    end
    n_cmp++;
    if ({trmt, tx_data, clr_rx_rdy} !== {1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_tx: trmt/tx_data/clr=%b/%h/%b, required 0/00/0", trmt, tx_data, clr_rx_rdy);
    end
    n_cmp++;
    if ({resp, resp_vld, cmd_ok, cmd_err, tmo} !== {8'h00, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_status: resp=%h vld/ok/err/tmo=%b%b%b%b, required 00 0000",
               resp, resp_vld, cmd_ok, cmd_err, tmo);
    end
  endtask

  task automatic test_basic();
    int c0 = n_clr;
    auto_tx = 1'b1; auto_rx = 1'b1; auto_rx_data = 8'hA5;
    expect_bytes(16'h2000, 1);
    expect_resp(8'hA5);
    push(16'h2000);
    wait_idle(200, "basic_idle");
    n_cmp++;
    if (n_clr - c0 !== 1) begin
      n_err++;
      $display("FAIL basic_clr: clr_rx_rdy pulses %0d, required 1", n_clr - c0);
    end
    n_cmp++;
    if (resp !== 8'hA5) begin
      n_err++;
      $display("FAIL basic_resp: resp=%h, required a5", resp);
    end
  endtask

  task automatic test_overflow();
    int o0;
    int t0 = n_trmt;
    auto_tx = 1'b0; auto_rx = 1'b1; auto_rx_data = 8'hA5;
    expect_bytes(16'h7777, 1);
    expect_resp(8'hA5);
    push(16'h7777);
    wait_trmts(t0 + 1, "ovf_blocker");
    o0 = n_ovf;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        expect_bytes(16'h43F0 + 16'(k), 1);
        expect_resp(8'hA5);
      end
      push(16'h43F0 + 16'(k));
    end
    n_cmp++;
    if ({count, full} !== {4'd8, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_level: count/full=%0d/%b, required 8/1", count, full);
    end
    tick(2);
    n_cmp++;
    if (n_ovf - o0 !== 1) begin
      n_err++;
      $display("FAIL ovf_pulse: ovf pulses %0d, required 1", n_ovf - o0);
    end
    auto_tx = 1'b1;
    tx_kick_seq++;
    wait_idle(2000, "ovf_drain");
  endtask

  task automatic test_bad_resp();
    auto_tx = 1'b1; auto_rx = 1'b1; auto_rx_data = 8'h5A;
    expect_bytes(16'h4001, 1);
    expect_resp(8'h5A);
    push(16'h4001);
    wait_idle(200, "bad_idle");
    n_cmp++;
    if (resp !== 8'h5A) begin
      n_err++;
      $display("FAIL bad_resp: resp=%h, required 5a", resp);
    end
  endtask

  task automatic test_timeout();
    stat_t s;
    int t0 = n_trmt;
    int elapsed = 0;
    bit seen = 1'b0;
    auto_tx = 1'b1; auto_rx = 1'b0; auto_rx_data = 8'hA5;
    s.vld = 1'b0; s.ok = 1'b0; s.err = 1'b1; s.tmo = 1'b1; s.resp = 8'h00;
    expect_bytes(16'h5111, ATTEMPTS);
    exp_stat.push_back(s);
    expect_bytes(16'h5222, 1);
    expect_resp(8'hA5);
    push(16'h5111);
    push(16'h5222);
    for (int i = 0; i < ATTEMPTS * 200 + 100 && !seen; i++) begin
      tick(1);
      elapsed++;
      if (tmo) seen = 1'b1;
    end
    auto_rx = 1'b1;
    n_cmp++;
    if (!seen || elapsed < ATTEMPTS * TMO || elapsed > ATTEMPTS * (TMO + 20) + 20) begin
      n_err++;
      $display("FAIL tmo_time: tmo seen=%b after %0d cycles, required within [%0d,%0d]",
               seen, elapsed, ATTEMPTS * TMO, ATTEMPTS * (TMO + 20) + 20);
    end
    n_cmp++;
    if (n_trmt - t0 !== 2 * ATTEMPTS) begin
      n_err++;
      $display("FAIL tmo_sends: %0d bytes before timeout, required %0d", n_trmt - t0, 2 * ATTEMPTS);
    end
    wait_idle(300, "tmo_next");
  endtask

  task automatic test_reset_abort();
    int t0 = n_trmt;
    bit [2:0] tseq;
    auto_tx = 1'b0; auto_rx = 1'b0;
    exp_bytes.push_back(8'h6A);
    push(16'h6A01); push(16'h6A02); push(16'h6A03);
    wait_trmts(t0 + 1, "abort_start");
    tick(2);
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({count, empty, busy, trmt} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abort_state: count/empty/busy/trmt=%0d/%b/%b/%b, required 0/1/0/0",
               count, empty, busy, trmt);
    end
    rst = 1'b0;
    n_cmp++;
    if (exp_bytes.size() !== 0) begin
      n_err++;
      $display("FAIL abort_bytes: %0d expected bytes unsent, required 0", exp_bytes.size());
    end
    auto_tx = 1'b1; auto_rx = 1'b1; auto_rx_data = 8'hA5;
    expect_bytes(16'h6022, 1);
    expect_resp(8'hA5);
    push(16'h6022);
    tseq[2] = trmt;
    tick(1);
    tseq[1] = trmt;
    tick(1);
    tseq[0] = trmt;
    n_cmp++;
    if (tseq !== 3'b001 || tx_data !== 8'h60) begin
      n_err++;
      $display("FAIL latency: trmt after N,N+1,N+2=%b tx_data=%h, required 001 60", tseq, tx_data);
    end
    wait_idle(200, "latency_idle");
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    bit [2:0] tseq;
    auto_tx = 1'b1; auto_rx = 1'b1; auto_rx_data = 8'hA5;
    expect_bytes(16'h1234, 1); expect_resp(8'hA5);
    expect_bytes(16'hABCD, 1); expect_resp(8'hA5);
    push(16'h1234);
    push(16'hABCD);
    for (int i = 0; i < 200 && !seen; i++) begin
      tick(1);
      if (resp_vld) seen = 1'b1;
    end
    tick(1); tseq[2] = trmt;
    tick(1); tseq[1] = trmt;
    tick(1); tseq[0] = trmt;
    n_cmp++;
    if (!seen || tseq !== 3'b001 || tx_data !== 8'hAB) begin
      n_err++;
      $display("FAIL b2b_latency: report seen=%b trmt seq=%b tx_data=%h, required 1 001 ab",
               seen, tseq, tx_data);
    end
    wait_idle(200, "b2b_idle");
  endtask

  task automatic test_stale_rx();
    int c0 = n_clr;
    rx_req_data = 8'h33;
    rx_req_seq++;
    tick(6);
    n_cmp++;
    if (n_clr - c0 !== 1 || rx_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL stale_clr: clr pulses %0d rx_rdy=%b, required 1 and 0", n_clr - c0, rx_rdy);
    end
    n_cmp++;
    if (resp !== last_resp || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stale_resp: resp=%h busy=%b, required %h and 0", resp, busy, last_resp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_wr = 1'b0; cmd_in = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_bad_resp();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    test_stale_rx();
    tick(5);
    n_cmp++;
    if (exp_bytes.size() !== 0 || exp_stat.size() !== 0) begin
      n_err++;
      $display("FAIL leftovers: %0d bytes and %0d statuses never seen, required 0 and 0",
               exp_bytes.size(), exp_stat.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cmd_queue_comm.md
Name: cmd_queue_comm

Overview:
- Parametrised successor to the team's single-shot remote command sender.
- Buffers up to DEPTH commands of CMD_W bits in a FIFO and serialises each one, MSB byte first, over a byte-wide UART transmitter handshake.
- Waits for the one-byte response with a timeout and reports per-command status.
- Sits between the bench/host command source and the UART TX/RX pair feeding the Knight.

Parameters:
CMD_W, 16, command width in bits; must be a multiple of 8 (NBYTES = CMD_W/8, 1..4)
DEPTH, 8, FIFO depth in commands; power of 2, 2..64
TIMEOUT_CYC, 1000000, clk cycles allowed in WAIT_RESP before a timeout
MAX_RETRY, 2, resend attempts after a timeout (used only with CMD_RETRY_EN)
RESP_DONE, 8'hA5, response byte counted as success

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_in  in  CMD_W  command to enqueue
cmd_wr  in  1  enqueue strobe
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH)+1  FIFO occupancy
ovf  out  1  1-cycle pulse: write dropped because FIFO was full
tx_data  out  8  byte to UART transmitter
trmt  out  1  1-cycle transmit strobe
tx_done  in  1  transmitter finished current byte
rx_data  in  8  received byte
rx_rdy  in  1  received byte valid (level, held until cleared)
clr_rx_rdy  out  1  1-cycle clear of rx_rdy
resp  out  8  last response byte captured
resp_vld  out  1  1-cycle pulse: resp updated
cmd_ok  out  1  1-cycle pulse, coincident with resp_vld, when resp == RESP_DONE
cmd_err  out  1  1-cycle pulse: bad response byte or final timeout
tmo  out  1  1-cycle pulse: final timeout (coincident with cmd_err)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, synchronous and active-high: FIFO cleared (count=0, empty=1, full=0); state IDLE; all pulse outputs 0; tx_data=0; resp=0. A reset asserted mid-operation aborts the command in flight with no status pulse.
- FIFO write: accepted when cmd_wr && !full. cmd_wr && full drops the command and pulses ovf for 1 cycle; count is unchanged.
- Simultaneous write and pop on a non-full FIFO: both occur and count is unchanged.
- States: IDLE, LOAD, SEND, WAIT_TX, WAIT_RESP, REPORT.
- IDLE: if !empty, go to LOAD.
- LOAD: pop the FIFO head into shift register sreg; byte index = NBYTES-1; retry count = 0; go to SEND.
- SEND: tx_data = byte[index] of sreg; trmt = 1 for 1 cycle; go to WAIT_TX.
- WAIT_TX on tx_done:
  - index > 0: decrement index, go to SEND.
  - index = 0: clear the timeout counter, go to WAIT_RESP.
- WAIT_RESP:
  - Timeout counter increments every cycle.
  - rx_rdy: capture rx_data into resp, pulse clr_rx_rdy, go to REPORT.
  - rx_rdy and the terminal count in the same cycle: rx_rdy wins.
  - Counter reaches TIMEOUT_CYC-1 with no rx_rdy: timeout handling (see Optional Feature).
- REPORT: resp_vld = 1 for 1 cycle. Also cmd_ok = 1 if resp == RESP_DONE, else cmd_err = 1. Go to IDLE.
- Stale rx_rdy in any state other than WAIT_RESP: clr_rx_rdy pulses the next cycle and the byte is discarded; resp is unchanged.
- Latency: a cmd_wr accepted at edge N with the FIFO empty and state IDLE gives trmt high in the cycle after edge N+2.
- Back-to-back: after REPORT, the next command's trmt follows at the same latency (IDLE to LOAD to SEND).
- tx_done in any state other than WAIT_TX is ignored.

Optional Feature:
- Macro: CMD_RETRY_EN.
- Defined: on timeout with retry count < MAX_RETRY, increment retry count, reload index = NBYTES-1, and resend the whole command from SEND. On timeout with retry count = MAX_RETRY, pulse cmd_err and tmo for 1 cycle and go to IDLE.
- Undefined: the first timeout pulses cmd_err and tmo and goes to IDLE. MAX_RETRY is unused.

Test Plan:
- Push 16'h2000; answer each trmt with tx_done 5 cycles later; present rx_data=8'hA5 -> tx_data sequence 8'h20 then 8'h00, resp=8'hA5, resp_vld and cmd_ok pulse together, clr_rx_rdy pulses once.
- DEPTH=8, hold tx_done low, push 9 commands 16'h43F1.. -> count=8, full=1, ovf pulses once on the 9th write, first 8 are later sent in order.
- Response 8'h5A to 16'h4001 -> resp_vld=1, cmd_ok=0, cmd_err=1, tmo=0.
- CMD_RETRY_EN, TIMEOUT_CYC=100, MAX_RETRY=2, no response -> command bytes transmitted 3 times, then cmd_err and tmo pulse together about 300 cycles after the first WAIT_RESP, then next FIFO entry starts. Without the macro -> single transmission, then cmd_err and tmo pulse.
- Assert rst in WAIT_TX with 3 entries queued -> next cycle count=0, busy=0, trmt=0, no status pulse. Push 16'h6022 -> trmt at the documented latency.
- rx_rdy=1 while IDLE -> clr_rx_rdy pulses, resp unchanged, no resp_vld.
